game_sequencer: RTL and testbench

- Top-level play controller for Dino Run.
- Sequences the game through attract, run, death hold-off and replay states.
- Generates the motion tick that paces the obstacle/sprite datapath, plus the restart pulse that re-initialises obstacle positions.
- Owns speed level, score and high score; consumes collision and obstacle-passed events from the obstacle datapath and the raw replay/start button from the controller report.

---
 rtl/game_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_game_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Dino Run play controller: attract/run/dead/over sequencing, motion tick
// generation, speed ramp, score and high-score keeping, replay button debounce.
module game_sequencer #(
  parameter int unsigned TICK_CYCLES     = 2000000,
  parameter int unsigned PASS_PER_LEVEL  = 12,
  parameter int unsigned MAX_SPEED       = 8,
  parameter int unsigned HOLDOFF_TICKS   = 25,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        collision,
  input  logic        obstacle_passed,
  output logic        motion_tick,
  output logic        restart,
  output logic        running,
  output logic        show_replay,
  output logic [3:0]  speed,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic [1:0]  state
);

  localparam int unsigned TickW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned PassW = (PASS_PER_LEVEL > 1) ? $clog2(PASS_PER_LEVEL) : 1;
  localparam int unsigned HoldW = (HOLDOFF_TICKS > 1) ? $clog2(HOLDOFF_TICKS) : 1;
  localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [TickW-1:0] TickLast = TickW'(TICK_CYCLES - 1);
  localparam logic [PassW-1:0] PassLast = PassW'(PASS_PER_LEVEL - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF_TICKS - 1);
  localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       MaxSpeed = 4'(MAX_SPEED);

  typedef enum logic [1:0] {
    StAttract = 2'd0,
    StRun     = 2'd1,
    StDead    = 2'd2,
    StOver    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             db_q, db_d;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [PassW-1:0] pass_cnt_q, pass_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]       speed_q, speed_d;
  logic [15:0]      score_q, score_d;
  logic [15:0]      hi_score_q, hi_score_d;
  logic             motion_tick_q, motion_tick_d;
  logic             restart_q, restart_d;
  logic             running_q, running_d;
  logic             show_replay_q, show_replay_d;

  logic             press;
  logic             tick_wrap;
  logic [TickW-1:0] tick_cnt_inc;
  logic             start_game;

  // Debounce: the level flips only after the synchronised input has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    press    = 1'b0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DbLast) begin
        db_d  = sync2_q;
        press = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Game sequencing, counters and registered output next-state.
  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    pass_cnt_d    = pass_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    speed_d       = speed_q;
    score_d       = score_q;
    hi_score_d    = hi_score_q;
    motion_tick_d = 1'b0;
    restart_d     = 1'b0;

    tick_wrap    = (tick_cnt_q == TickLast);
    tick_cnt_inc = tick_wrap ? '0 : tick_cnt_q + 1'b1;
    start_game   = press && ((state_q == StAttract) || (state_q == StOver));

    unique case (state_q)
      StAttract: ;
      StRun: begin
        tick_cnt_d = tick_cnt_inc;
        if (collision) begin
          // Collision cycle swallows that cycle's tick, score and pass.
          state_d    = StDead;
          hold_cnt_d = '0;
          hi_score_d = (score_q > hi_score_q) ? score_q : hi_score_q;
        end else begin
          if (tick_wrap) begin
            motion_tick_d = 1'b1;
            if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
          end
          if (obstacle_passed) begin
            if (pass_cnt_q == PassLast) begin
              pass_cnt_d = '0;
              if (speed_q < MaxSpeed) speed_d = speed_q + 4'd1;
            end else begin
              pass_cnt_d = pass_cnt_q + 1'b1;
            end
          end
        end
      end
      StDead: begin
        tick_cnt_d = tick_cnt_inc;
        if (tick_wrap) begin
          if (hold_cnt_q == HoldLast) state_d = StOver;
          else hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StOver: ;
      default: state_d = StAttract;
    endcase

    if (start_game) begin
      restart_d  = 1'b1;
      score_d    = '0;
      speed_d    = 4'd1;
      pass_cnt_d = '0;
      tick_cnt_d = '0;
      state_d    = StRun;
    end

    running_d     = (state_d == StRun);
    show_replay_d = (state_d == StOver);
  end

  // All state, with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StAttract;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      db_q          <= 1'b0;
      db_cnt_q      <= '0;
      tick_cnt_q    <= '0;
      pass_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      speed_q       <= 4'd1;
      score_q       <= '0;
      hi_score_q    <= '0;
      motion_tick_q <= 1'b0;
      restart_q     <= 1'b0;
      running_q     <= 1'b0;
      show_replay_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= start_btn;
      sync2_q       <= sync1_q;
      db_q          <= db_d;
      db_cnt_q      <= db_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      pass_cnt_q    <= pass_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      speed_q       <= speed_d;
      score_q       <= score_d;
      hi_score_q    <= hi_score_d;
      motion_tick_q <= motion_tick_d;
      restart_q     <= restart_d;
      running_q     <= running_d;
      show_replay_q <= show_replay_d;
    end
  end

  assign motion_tick = motion_tick_q;
  assign restart     = restart_q;
  assign running     = running_q;
  assign show_replay = show_replay_q;
  assign speed       = speed_q;
  assign score       = score_q;
  assign hi_score    = hi_score_q;
  assign state       = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: expected restart snapshots and
// per-tick scores are queued as games are started and checked as pulses appear.
module tb_game_sequencer;

  localparam int Tick = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_btn = 1'b0;
  logic        collision = 1'b0;
  logic        obstacle_passed = 1'b0;
  logic        motion_tick, restart, running, show_replay;
  logic [3:0]  speed;
  logic [15:0] score, hi_score;
  logic [1:0]  state;

  game_sequencer #(
    .TICK_CYCLES    (4),
    .PASS_PER_LEVEL (3),
    .MAX_SPEED      (3),
    .HOLDOFF_TICKS  (2),
    .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_btn      (start_btn),
    .collision      (collision),
    .obstacle_passed(obstacle_passed),
    .motion_tick    (motion_tick),
    .restart        (restart),
    .running        (running),
    .show_replay    (show_replay),
    .speed          (speed),
    .score          (score),
    .hi_score       (hi_score),
    .state          (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int off;
    int sc;
  } tick_t;

  tick_t tick_q[$];
  int    hi_q[$];
  int    rst_cnt = 0;
  int    rst_cyc = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) step();
  endtask

  task automatic wait_restart(input int bound);
    int n;
    n = rst_cnt;
    for (int i = 0; i < bound; i++) begin
      step();
      if (rst_cnt != n) break;
    end
    check_val("restart_seen", rst_cnt - n, 1);
  endtask

  task automatic wait_over(input int bound);
    for (int i = 0; i < bound; i++) begin
      step();
      if (state == 2'd3) break;
    end
  endtask

  task automatic push_game(input int hi, input int nticks);
    tick_t t;
    hi_q.push_back(hi);
    for (int i = 1; i <= nticks; i++) begin
      t.off = Tick * i;
      t.sc  = i;
      tick_q.push_back(t);
    end
  endtask

  // Output monitor: pops expectations whenever restart or motion_tick fires.
  initial begin
    int    h;
    tick_t t;
    forever begin
      @(negedge clk);
      if (restart) begin
        rst_cnt++;
        rst_cyc = cyc;
        if (hi_q.size() == 0) begin
          check_val("restart_extra", 1, 0);
        end else begin
          h = hi_q.pop_front();
          check_val("rs_hi", int'(hi_score), h);
          check_val("rs_score", int'(score), 0);
          check_val("rs_speed", int'(speed), 1);
          check_val("rs_running", int'(running), 1);
          check_val("rs_state", int'(state), 1);
        end
      end
      if (motion_tick) begin
        if (tick_q.size() == 0) begin
          check_val("tick_extra", 1, 0);
        end else begin
          t = tick_q.pop_front();
          check_val("tick_off", cyc - rst_cyc, t.off);
          check_val("tick_score", int'(score), t.sc);
        end
      end
    end
  end

  initial begin
    int c;
    // Reset state
    repeat (3) step();
    check_val("rst_state", int'(state), 0);
    check_val("rst_flags", int'({motion_tick, restart, running, show_replay}), 0);
    check_val("rst_speed", int'(speed), 1);
    check_val("rst_score", int'(score), 0);
    check_val("rst_hi", int'(hi_score), 0);
    reset = 1'b0;

    // Passes and bouncing button in ATTRACT have no effect
    obstacle_passed = 1'b1;
    repeat (3) step();
    obstacle_passed = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start_btn = ~start_btn;
      repeat (2) step();
    end
    start_btn = 1'b0;
    repeat (5) step();
    check_val("bounce_state", int'(state), 0);
    check_val("bounce_restarts", rst_cnt, 0);
    check_val("attract_speed", int'(speed), 1);

    // Game 1: held button gives one restart; dies at score 7
    push_game(0, 7);
    start_btn = 1'b1;
    repeat (10) step();
    start_btn = 1'b0;
    check_val("start_restarts", rst_cnt, 1);
    c = rst_cyc;
    wait_until(c + 20);
    check_val("g1_score20", int'(score), 5);
    wait_until(c + 31);
    collision = 1'b1;
    step();
    collision = 1'b0;
    check_val("g1_coll_tick", int'(motion_tick), 0);
    check_val("g1_dead_state", int'(state), 2);
    check_val("g1_dead_running", int'(running), 0);
    check_val("g1_dead_hi", int'(hi_score), 7);
    check_val("g1_dead_score", int'(score), 7);
    // Press and passes during DEAD are ignored
    start_btn = 1'b1;
    obstacle_passed = 1'b1;
    repeat (3) step();
    obstacle_passed = 1'b0;
    repeat (2) step();
    start_btn = 1'b0;
    wait_over(12);
    check_val("g1_dead_len", cyc - c, 40);
    check_val("g1_over_state", int'(state), 3);
    check_val("g1_over_replay", int'(show_replay), 1);
    check_val("g1_over_speed", int'(speed), 1);
    check_val("g1_over_score", int'(score), 7);
    repeat (6) step();
    check_val("g1_over_hold", int'(state), 3);
    check_val("g1_over_restarts", rst_cnt, 1);

    // Game 2: replay, speed ramp with saturation, dies at score 3
    push_game(7, 3);
    start_btn = 1'b1;
    wait_restart(15);
    start_btn = 1'b0;
    c = rst_cyc;
    obstacle_passed = 1'b1;
    repeat (3) step();
    check_val("g2_speed3", int'(speed), 2);
    repeat (3) step();
    check_val("g2_speed6", int'(speed), 3);
    repeat (3) step();
    obstacle_passed = 1'b0;
    check_val("g2_speed9", int'(speed), 3);
    wait_until(c + 15);
    collision = 1'b1;
    step();
    collision = 1'b0;
    check_val("g2_dead_state", int'(state), 2);
    check_val("g2_dead_score", int'(score), 3);
    check_val("g2_dead_hi", int'(hi_score), 7);
    wait_over(12);
    check_val("g2_over_state", int'(state), 3);
    check_val("g2_over_hi", int'(hi_score), 7);
    repeat (6) step();

    // Game 3: reset mid-run at score 9
    push_game(7, 9);
    start_btn = 1'b1;
    wait_restart(15);
    start_btn = 1'b0;
    c = rst_cyc;
    wait_until(c + 36);
    check_val("g3_score", int'(score), 9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("mid_rst_state", int'(state), 0);
    check_val("mid_rst_score", int'(score), 0);
    check_val("mid_rst_hi", int'(hi_score), 0);
    check_val("mid_rst_speed", int'(speed), 1);
    check_val("mid_rst_flags", int'({motion_tick, restart, running, show_replay}), 0);
    repeat (6) step();
    check_val("sb_ticks_left", tick_q.size(), 0);
    check_val("sb_restarts_left", hi_q.size(), 0);
    check_val("total_restarts", rst_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
